irq_ctrl18: RTL and testbench

Interrupt controller that drives the Core18 `VECTOR[3:0]` input from a bank of external request lines. It latches rising edges into a pending register, applies a software mask and selects the highest-priority request. It presents a stable vector until the core acknowledges by branching to the vector address. Mask and pending registers sit on the Core18 port bus, and the core's `RESET` opcode output clears controller state.

---
 rtl/irq18_pkg.sv | 13 +
 rtl/irq18_edge.sv | 29 ++
 rtl/irq_ctrl18.sv | 166 ++++++++++++++++
 tb/tb_irq_ctrl18.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq18_pkg.sv
// Shared types and default port addresses for the Core18 interrupt controller.
package irq18_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } irq_state_t;

    localparam logic [17:0] MASK_ADR_DEFAULT = 18'o000020;
    localparam logic [17:0] PEND_ADR_DEFAULT = 18'o000021;

endpackage

// File: rtl/irq18_edge.sv
// Two-flop synchronizer for one asynchronous request line, followed by a
// previous-value flop so a rising edge yields a single-cycle pulse.
module irq18_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronize the raw line and remember last cycle's synchronized value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/irq_ctrl18.sv
// Core18 interrupt controller: edge-captured pending bits, software mask,
// fixed lowest-index-first priority and a vector handshake FSM that releases
// the vector once the core branches to it.
module irq_ctrl18
    import irq18_pkg::*;
#(
    parameter int          NIRQ     = 8,
    parameter int          VBASE    = 8,
    parameter int          HOLDOFF  = 2,
    parameter logic [17:0] MASK_ADR = MASK_ADR_DEFAULT,
    parameter logic [17:0] PEND_ADR = PEND_ADR_DEFAULT
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [NIRQ-1:0] IRQ,
    input  logic            SOFT_RESET,
    input  logic [11:0]     PC,
    input  logic            PORT_WR,
    input  logic            PORT_RD,
    input  logic [17:0]     ADRS,
    input  logic [17:0]     DATAOUT,
    output logic [3:0]      VECTOR,
    output logic [17:0]     PORT_DATA,
    output logic            PORT_HIT
);

    // Holdoff counter is at least one bit wide even for HOLDOFF of 0 or 1.
    localparam int CW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

    irq_state_t      state_q,   state_d;
    logic [3:0]      vector_q,  vector_d;
    logic [3:0]      idx_q,     idx_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] mask_q,    mask_d;

    logic [NIRQ-1:0] edge_vec;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] k_onehot;
    logic [NIRQ-1:0] ack_clr;
    logic [NIRQ-1:0] pend_clr;
    logic [3:0]      sel_idx;
    logic            any_elig;
    logic            wr_mask;
    logic            wr_pend;
    logic            adr_mask;
    logic            adr_pend;
    logic            unused_dataout;

    genvar g;
    generate
        for (g = 0; g < NIRQ; g++) begin : g_edge
            irq18_edge u_edge (
                .clk   (CLK),
                .rst_n (RESET_N),
                .irq   (IRQ[g]),
                .rise  (edge_vec[g])
            );
        end
    endgenerate

    assign adr_mask       = (ADRS == MASK_ADR);
    assign adr_pend       = (ADRS == PEND_ADR);
    assign wr_mask        = PORT_WR && adr_mask;
    assign wr_pend        = PORT_WR && adr_pend;
    assign eligible       = pending_q & mask_q;
    assign k_onehot       = NIRQ'(1) << idx_q;
    assign VECTOR         = vector_q;
    assign unused_dataout = ^DATAOUT[17:NIRQ];

    // Read-side port decode; data is zero-extended from the NIRQ-bit registers.
    always_comb begin
        PORT_HIT  = PORT_RD && (adr_mask || adr_pend);
        PORT_DATA = '0;
        if (adr_mask) begin
            PORT_DATA = 18'(mask_q);
        end else if (adr_pend) begin
            PORT_DATA = 18'(pending_q);
        end
    end

    // Priority encoder: scanning downward leaves the lowest eligible index.
    always_comb begin
        any_elig = |eligible;
        sel_idx  = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_idx = 4'(i);
            end
        end
    end

    // Next-state logic for the vector FSM and the pending/mask registers.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ack_clr  = '0;

        case (state_q)
            IDLE: begin
                vector_d = '0;
                if (any_elig) begin
                    idx_d    = sel_idx;
                    vector_d = 4'(VBASE) + sel_idx;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (PC == {8'b0, vector_q}) begin
                    ack_clr  = k_onehot;
                    vector_d = '0;
                    cnt_d    = CW'(HOLDOFF);
                    state_d  = (HOLDOFF == 0) ? IDLE : HOLD;
                end else if (((pending_q & k_onehot) == '0) ||
                             ((mask_q & k_onehot) == '0)) begin
                    vector_d = '0;
                    state_d  = IDLE;
                end
            end
            HOLD: begin
                vector_d = '0;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                vector_d = '0;
                state_d  = IDLE;
            end
        endcase

        pend_clr  = (wr_pend ? DATAOUT[NIRQ-1:0] : '0) | ack_clr;
        pending_d = (pending_q & ~pend_clr) | edge_vec;
        mask_d    = wr_mask ? DATAOUT[NIRQ-1:0] : mask_q;

        if (SOFT_RESET) begin
            state_d   = IDLE;
            vector_d  = '0;
            pending_d = '0;
            mask_d    = '0;
        end
    end

    // Register the FSM, vector, holdoff count and software-visible registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            vector_q  <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            vector_q  <= vector_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl18.sv
// Directed testbench for irq_ctrl18 with the default parameters
// (NIRQ=8, VBASE=8, HOLDOFF=2). Inputs change and outputs are observed on
// the falling edge of the clock.
module tb_irq_ctrl18;

    localparam logic [17:0] MASK_A = 18'o000020;
    localparam logic [17:0] PEND_A = 18'o000021;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  irq;
    logic        soft_reset;
    logic [11:0] pc;
    logic        port_wr;
    logic        port_rd;
    logic [17:0] adrs;
    logic [17:0] dataout;
    logic [3:0]  vector;
    logic [17:0] port_data;
    logic        port_hit;

    int checks = 0;
    int errors = 0;

    logic [17:0] rd_data;
    logic        rd_hit;

    irq_ctrl18 #(
        .NIRQ     (8),
        .VBASE    (8),
        .HOLDOFF  (2),
        .MASK_ADR (18'o000020),
        .PEND_ADR (18'o000021)
    ) dut (
        .CLK        (clk),
        .RESET_N    (reset_n),
        .IRQ        (irq),
        .SOFT_RESET (soft_reset),
        .PC         (pc),
        .PORT_WR    (port_wr),
        .PORT_RD    (port_rd),
        .ADRS       (adrs),
        .DATAOUT    (dataout),
        .VECTOR     (vector),
        .PORT_DATA  (port_data),
        .PORT_HIT   (port_hit)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic port_write(input logic [17:0] adr, input logic [17:0] data);
        port_wr = 1'b1;
        adrs    = adr;
        dataout = data;
        @(negedge clk);
        port_wr = 1'b0;
        adrs    = '0;
        dataout = '0;
    endtask

    task automatic port_read(input logic [17:0] adr, output logic [17:0] data, output logic hit);
        port_rd = 1'b1;
        adrs    = adr;
        #1;
        data    = port_data;
        hit     = port_hit;
        port_rd = 1'b0;
        adrs    = '0;
    endtask

    task automatic test_reset();
        if (vector !== 4'd0) begin
            $display("[TB] FAIL por_vector: got %0d expected 0", vector); errors++;
        end
        checks++;
        port_read(PEND_A, rd_data, rd_hit);
        if (rd_data !== 18'h0 || rd_hit !== 1'b1) begin
            $display("[TB] FAIL por_pend: got %h hit %b expected 0 hit 1", rd_data, rd_hit); errors++;
        end
        checks++;
        port_write(MASK_A, 18'h0FF);
        irq[5] = 1'b1;
        step(4);
        if (vector !== 4'd13) begin
            $display("[TB] FAIL pre_reset_vector: got %0d expected 13", vector); errors++;
        end
        checks++;
        reset_n = 1'b0;
        #1;
        if (vector !== 4'd0) begin
            $display("[TB] FAIL reset_vector: got %0d expected 0", vector); errors++;
        end
        checks++;
        port_read(MASK_A, rd_data, rd_hit);
        if (rd_data !== 18'h0) begin
            $display("[TB] FAIL reset_mask: got %h expected 0", rd_data); errors++;
        end
        checks++;
        port_read(PEND_A, rd_data, rd_hit);
        if (rd_data !== 18'h0) begin
            $display("[TB] FAIL reset_pend: got %h expected 0", rd_data); errors++;
        end
        checks++;
        irq[5] = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(4);
        if (vector !== 4'd0) begin
            $display("[TB] FAIL post_reset_vector: got %0d expected 0", vector); errors++;
        end
        checks++;
    endtask

    task automatic test_single();
        port_write(MASK_A, 18'h001);
        port_read(MASK_A, rd_data, rd_hit);
        if (rd_data !== 18'h001) begin
            $display("[TB] FAIL single_mask_rd: got %h expected 001", rd_data); errors++;
        end
        checks++;
        irq[0] = 1'b1;
        step(3);
        if (vector !== 4'd0) begin
            $display("[TB] FAIL single_before_e3: got %0d expected 0", vector); errors++;
        end
        checks++;
        step(1);
        if (vector !== 4'd8) begin
            $display("[TB] FAIL single_after_e3: got %0d expected 8", vector); errors++;
        end
        checks++;
        pc = 12'o0010;
        step(1);
        pc = 12'd0;
        if (vector !== 4'd0) begin
            $display("[TB] FAIL single_ack_vector: got %0d expected 0", vector); errors++;
        end
        checks++;
        port_read(PEND_A, rd_data, rd_hit);
        if (rd_data !== 18'h0) begin
            $display("[TB] FAIL single_ack_pend: got %h expected 0", rd_data); errors++;
        end
        checks++;
        step(5);
        if (vector !== 4'd0) begin
            $display("[TB] FAIL single_no_repeat: got %0d expected 0", vector); errors++;
        end
        checks++;
        irq[0] = 1'b0;
        step(3);
    endtask

    task automatic test_priority();
        port_write(MASK_A, 18'h0FF);
        irq[3] = 1'b1;
        irq[1] = 1'b1;
        step(4);
        if (vector !== 4'd9) begin
            $display("[TB] FAIL prio_first: got %0d expected 9", vector); errors++;
        end
        checks++;
        pc = 12'd9;
        step(1);
        pc = 12'd0;
        if (vector !== 4'd0) begin
            $display("[TB] FAIL prio_ack1: got %0d expected 0", vector); errors++;
        end
        checks++;
        port_read(PEND_A, rd_data, rd_hit);
        if (rd_data !== 18'h008) begin
            $display("[TB] FAIL prio_pend_after_ack1: got %h expected 008", rd_data); errors++;
        end
        checks++;
        step(2);
        if (vector !== 4'd0) begin
            $display("[TB] FAIL prio_holdoff: got %0d expected 0", vector); errors++;
        end
        checks++;
        step(1);
        if (vector !== 4'd11) begin
            $display("[TB] FAIL prio_second: got %0d expected 11", vector); errors++;
        end
        checks++;
        pc = 12'd11;
        step(1);
        pc = 12'd0;
        step(4);
        if (vector !== 4'd0) begin
            $display("[TB] FAIL prio_after_ack2: got %0d expected 0", vector); errors++;
        end
        checks++;
        irq[3] = 1'b0;
        irq[1] = 1'b0;
        step(3);
    endtask

    task automatic test_masked();
        port_write(MASK_A, 18'h000);
        irq[2] = 1'b1;
        step(4);
        port_read(PEND_A, rd_data, rd_hit);
        if (rd_data !== 18'h004) begin
            $display("[TB] FAIL masked_pend: got %h expected 004", rd_data); errors++;
        end
        checks++;
        if (vector !== 4'd0) begin
            $display("[TB] FAIL masked_vector: got %0d expected 0", vector); errors++;
        end
        checks++;
        port_write(MASK_A, 18'h004);
        if (vector !== 4'd0) begin
            $display("[TB] FAIL unmask_at_write: got %0d expected 0", vector); errors++;
        end
        checks++;
        step(1);
        if (vector !== 4'd10) begin
            $display("[TB] FAIL unmask_vector: got %0d expected 10", vector); errors++;
        end
        checks++;
        pc = 12'd10;
        step(1);
        pc = 12'd0;
        step(3);
        irq[2] = 1'b0;
        step(3);
    endtask

    task automatic test_withdraw();
        port_write(MASK_A, 18'h001);
        irq[0] = 1'b1;
        step(4);
        if (vector !== 4'd8) begin
            $display("[TB] FAIL wd_assert: got %0d expected 8", vector); errors++;
        end
        checks++;
        port_write(PEND_A, 18'h001);
        step(1);
        if (vector !== 4'd0) begin
            $display("[TB] FAIL wd_vector: got %0d expected 0", vector); errors++;
        end
        checks++;
        step(2);
        port_read(PEND_A, rd_data, rd_hit);
        if (rd_data !== 18'h0 || vector !== 4'd0) begin
            $display("[TB] FAIL wd_idle: pend %h vector %0d expected pend 0 vector 0", rd_data, vector); errors++;
        end
        checks++;
    endtask

    task automatic test_set_wins();
        irq[0] = 1'b0;
        step(4);
        irq[0] = 1'b1;
        step(4);
        if (vector !== 4'd8) begin
            $display("[TB] FAIL sw_assert: got %0d expected 8", vector); errors++;
        end
        checks++;
        irq[0] = 1'b0;
        step(4);
        irq[0] = 1'b1;
        step(2);
        port_write(PEND_A, 18'h001);
        port_read(PEND_A, rd_data, rd_hit);
        if (rd_data !== 18'h001) begin
            $display("[TB] FAIL sw_pend: got %h expected 001", rd_data); errors++;
        end
        checks++;
        step(2);
        if (vector !== 4'd8) begin
            $display("[TB] FAIL sw_vector: got %0d expected 8", vector); errors++;
        end
        checks++;
        pc = 12'd8;
        step(1);
        pc = 12'd0;
        step(3);
        irq[0] = 1'b0;
        step(3);
    endtask

    task automatic test_soft_reset();
        irq[0] = 1'b1;
        step(4);
        if (vector !== 4'd8) begin
            $display("[TB] FAIL sr_assert: got %0d expected 8", vector); errors++;
        end
        checks++;
        soft_reset = 1'b1;
        port_write(MASK_A, 18'h0FF);
        soft_reset = 1'b0;
        if (vector !== 4'd0) begin
            $display("[TB] FAIL sr_vector: got %0d expected 0", vector); errors++;
        end
        checks++;
        port_read(MASK_A, rd_data, rd_hit);
        if (rd_data !== 18'h0) begin
            $display("[TB] FAIL sr_mask: got %h expected 0", rd_data); errors++;
        end
        checks++;
        port_read(PEND_A, rd_data, rd_hit);
        if (rd_data !== 18'h0) begin
            $display("[TB] FAIL sr_pend: got %h expected 0", rd_data); errors++;
        end
        checks++;
        step(5);
        if (vector !== 4'd0) begin
            $display("[TB] FAIL sr_quiet: got %0d expected 0", vector); errors++;
        end
        checks++;
        irq[0] = 1'b0;
        step(4);
        port_write(MASK_A, 18'h001);
        irq[0] = 1'b1;
        step(4);
        if (vector !== 4'd8) begin
            $display("[TB] FAIL sr_recover: got %0d expected 8", vector); errors++;
        end
        checks++;
    endtask

    // Sequence all scenarios, then report.
    initial begin
        reset_n    = 1'b0;
        irq        = '0;
        soft_reset = 1'b0;
        pc         = '0;
        port_wr    = 1'b0;
        port_rd    = 1'b0;
        adrs       = '0;
        dataout    = '0;
        step(2);
        reset_n = 1'b1;
        step(1);

        test_reset();
        test_single();
        test_priority();
        test_masked();
        test_withdraw();
        test_set_wins();
        test_soft_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
